// File: rtl/sar_search_pkg.sv
// rtl/sar_search_pkg.sv - shared state type, range constant and width helper for sar_search
package sar_search_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        PROBE = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int MAX       = (1 << DEF_WIDTH) - 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sar_search.sv
// rtl/sar_search.sv - successive-approximation search driving the b operand of a magnitude comparator
module sar_search
    import sar_search_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             oa,
    input  logic             oe,
    input  logic             ob,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic [WIDTH-1:0] found,
    output logic             err
);

    localparam int               CW   = clog2(WIDTH + 2);
    localparam logic [WIDTH-1:0] MAXV = {WIDTH{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] found_q, found_d;
    logic             hit_q, hit_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   sum;
    logic             flags_onehot;
    logic             fail;

    // Midpoint needs the carry bit so lo+hi cannot wrap before the halving.
    assign sum   = {1'b0, lo_q} + {1'b0, hi_q};
    assign guess = WIDTH'(sum >> 1);

    assign busy  = (state_q == PROBE);
    assign done  = done_q;
    assign hit   = hit_q;
    assign found = found_q;
    assign err   = err_q;

    assign flags_onehot = ({oa, oe, ob} == 3'b100) || ({oa, oe, ob} == 3'b010) ||
                          ({oa, oe, ob} == 3'b001);
    // Traps inconsistent comparators before lo/hi could step past the range ends.
    assign fail = !flags_onehot || (oa && guess == MAXV) || (ob && guess == '0) ||
                  (cnt_q == CW'(WIDTH) && !oe);

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        found_d = found_q;
        hit_d   = hit_q;
        err_d   = err_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                lo_d    = '0;
                hi_d    = MAXV;
                cnt_d   = '0;
                err_d   = 1'b0;
                hit_d   = 1'b0;
                found_d = '0;
                state_d = PROBE;
            end
        end else begin
            if (fail) begin
                err_d   = 1'b1;
                hit_d   = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end else if (oe) begin
                found_d = guess;
                hit_d   = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end else if (oa) begin
                lo_d  = guess + WIDTH'(1);
                cnt_d = cnt_q + CW'(1);
            end else begin
                hi_d  = guess - WIDTH'(1);
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lo_q    <= '0;
            hi_q    <= MAXV;
            cnt_q   <= '0;
            found_q <= '0;
            hit_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            found_q <= found_d;
            hit_q   <= hit_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// tb/tb_sar_search.sv - randomized self-checking bench for sar_search with a behavioural search model
module tb_sar_search;

    typedef struct {
        logic       busy;
        logic       done;
        logic       hit;
        logic       err;
        logic [3:0] guess;
        logic [3:0] found;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       oa, oe, ob;
    logic [3:0] guess;
    logic       busy, done, hit, err;
    logic [3:0] found;

    int unknown;
    int mode;      // 0 honest comparator, 1 oa+oe both high, 2 oa stuck, 3 ob stuck
    int n_checks;
    int n_fail;

    exp_t exp_q[$];

    // model of the current search
    int p_q[$];
    bit p_hit;
    bit m_busy;
    int m_idx;
    bit m_done, m_hit, m_err;
    int m_found, m_guess;
    int plan_saved[$];
    bit plan_hit_saved;

    sar_search #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .oa(oa), .oe(oe), .ob(ob),
        .guess(guess), .busy(busy), .done(done),
        .hit(hit), .found(found), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] flags_of(input int uu, input int md, input int g);
        case (md)
            1:       return 3'b110;
            2:       return 3'b100;
            3:       return 3'b001;
            default: return {uu > g, uu == g, uu < g};
        endcase
    endfunction

    always_comb begin
        {oa, oe, ob} = flags_of(unknown, mode, int'(guess));
    end

    // Plain binary search over 0..15 with the termination rules applied to each probe.
    task automatic plan(input int uu, input int md);
        int lo, hi, g;
        logic [2:0] f;
        bit onehot;
        lo = 0; hi = 15;
        p_q.delete();
        p_hit = 1'b0;
        for (int k = 0; k < 5; k++) begin
            g = (lo + hi) / 2;
            p_q.push_back(g);
            f = flags_of(uu, md, g);
            onehot = (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
            if (!onehot || (f[2] && g == 15) || (f[0] && g == 0) || (k == 4 && !f[1])) begin
                p_hit = 1'b0;
                return;
            end else if (f[1]) begin
                p_hit = 1'b1;
                return;
            end else if (f[2]) begin
                lo = g + 1;
            end else begin
                hi = g - 1;
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    // One clock cycle: drive inputs, record what the outputs must be, advance the model.
    task automatic step(input bit s, input bit r);
        exp_t e;
        start = s;
        rst   = r;
        if (r) begin
            m_busy = 0; m_done = 0; m_hit = 0; m_err = 0; m_found = 0; m_guess = 7;
        end
        e.busy  = m_busy;
        e.done  = m_done;
        e.hit   = m_busy ? 1'b0 : m_hit;
        e.err   = m_busy ? 1'b0 : m_err;
        e.found = m_busy ? 4'd0 : 4'(m_found);
        e.guess = m_busy ? 4'(plan_saved[m_idx]) : 4'(m_guess);
        exp_q.push_back(e);
        if (!r) begin
            if (m_busy) begin
                m_idx++;
                if (m_idx == plan_saved.size()) begin
                    m_busy  = 0;
                    m_done  = 1;
                    m_hit   = plan_hit_saved;
                    m_err   = !plan_hit_saved;
                    m_guess = plan_saved[m_idx-1];
                    m_found = plan_hit_saved ? plan_saved[m_idx-1] : 0;
                end
            end else begin
                m_done = 0;
                if (s) begin
                    plan(unknown, mode);
                    plan_saved = p_q;
                    plan_hit_saved = p_hit;
                    m_busy = 1; m_idx = 0; m_hit = 0; m_err = 0; m_found = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_search(input int uu, input int md, input bit hold_start);
        unknown = uu;
        mode    = md;
        step(1'b1, 1'b0);
        while (m_busy) step(hold_start, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("busy",  int'(busy),  int'(e.busy));
            chk("done",  int'(done),  int'(e.done));
            chk("hit",   int'(hit),   int'(e.hit));
            chk("err",   int'(err),   int'(e.err));
            chk("guess", int'(guess), int'(e.guess));
            chk("found", int'(found), int'(e.found));
        end
    end

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1; start = 1'b0; unknown = 0; mode = 0;
        m_busy = 0; m_done = 0; m_hit = 0; m_err = 0; m_found = 0; m_guess = 7; m_idx = 0;

        // hand-computed search paths pin the model
        plan(9, 0);
        chk("plan9_len", p_q.size(), 3);
        chk("plan9_g0", p_q[0], 7); chk("plan9_g1", p_q[1], 11); chk("plan9_g2", p_q[2], 9);
        chk("plan9_hit", int'(p_hit), 1);
        plan(15, 0);
        chk("plan15_len", p_q.size(), 5); chk("plan15_g3", p_q[3], 14); chk("plan15_g4", p_q[4], 15);
        plan(0, 0);
        chk("plan0_len", p_q.size(), 4); chk("plan0_g2", p_q[2], 1); chk("plan0_g3", p_q[3], 0);
        plan(4, 1);
        chk("plan_dual_len", p_q.size(), 1); chk("plan_dual_hit", int'(p_hit), 0);
        plan(4, 2);
        chk("plan_oa_len", p_q.size(), 5); chk("plan_oa_last", p_q[4], 15);
        plan(4, 3);
        chk("plan_ob_len", p_q.size(), 4); chk("plan_ob_last", p_q[3], 0);
        for (int u = 0; u < 16; u++) begin
            plan(u, 0);
            chk("plan_sweep_hit", int'(p_hit), 1);
            chk("plan_sweep_found", p_q[p_q.size()-1], u);
        end

        @(posedge clk);
        #1;
        repeat (3) step(1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0);

        run_search(9, 0, 1'b0);  step(1'b0, 1'b0); step(1'b0, 1'b0);
        run_search(15, 0, 1'b0); step(1'b0, 1'b0);
        run_search(0, 0, 1'b0);  step(1'b0, 1'b0);

        for (int u = 0; u < 16; u++) run_search(u, 0, 1'b0);
        step(1'b0, 1'b0);

        run_search(6, 1, 1'b0); step(1'b0, 1'b0);
        run_search(6, 2, 1'b0); step(1'b0, 1'b0);
        run_search(6, 3, 1'b0); step(1'b0, 1'b0);

        unknown = 12; mode = 0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        run_search(12, 0, 1'b0); step(1'b0, 1'b0);

        unknown = 5; mode = 0;
        repeat (20) step(1'b1, 1'b0);
        while (m_busy) step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            int md;
            md = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            repeat ($urandom_range(0, 2)) step(1'(($urandom_range(0, 1))) & 1'b0, 1'b0);
            run_search(int'($urandom_range(0, 15)), md, 1'($urandom_range(0, 1)));
        end
        repeat (3) step(1'b0, 1'b0);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
